// File: rtl/div_if.sv
// rtl/div_if.sv - request/result bundle between the MIX sequencer and the divider
//
// Purpose: carries one divide request (start, dividend, divisor) into the
// divider and its registered results (quotient, remainder, overflow, status)
// back out.
// Ports (signals):
//   i_start    - one-cycle request, sampled only while the divider is idle
//   i_a        - 2W-bit dividend, i_a[2W-1:W] = rA magnitude, i_a[W-1:0] = rX
//   i_b        - W-bit divisor magnitude
//   o_quot     - W-bit quotient (new rA magnitude)
//   o_rem      - W-bit remainder (new rX magnitude)
//   o_overflow - quotient not representable in W bits (or divide by zero)
//   o_busy     - operation in progress
//   o_done     - single-cycle pulse, results valid
// Modports: master = sequencer side, slave = divider side.
interface div_if #(
  parameter int W = 30
);
  logic           i_start;
  logic [2*W-1:0] i_a;
  logic [W-1:0]   i_b;
  logic [W-1:0]   o_quot;
  logic [W-1:0]   o_rem;
  logic           o_overflow;
  logic           o_busy;
  logic           o_done;

  modport master (
    output i_start, i_a, i_b,
    input  o_quot, o_rem, o_overflow, o_busy, o_done
  );

  modport slave (
    input  i_start, i_a, i_b,
    output o_quot, o_rem, o_overflow, o_busy, o_done
  );
endinterface

// File: rtl/div.sv
// rtl/div.sv - sequential restoring unsigned divider for the MIX arithmetic unit
//
// Purpose: divides the 2W-bit magnitude rA:rX by the W-bit magnitude V,
// producing one quotient bit per clock. Signs are handled by the sequencer.
// Ports:
//   i_clk   - system clock, all state changes on the rising edge
//   i_reset - synchronous active-high reset, wins over everything
//   bus     - div_if.slave: i_start/i_a/i_b in, o_quot/o_rem/o_overflow/
//             o_busy/o_done out (all outputs registered)
module div #(
  parameter int W = 30
) (
  input  logic i_clk,
  input  logic i_reset,
  div_if.slave bus
);

  localparam int         CW       = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [W-1:0]  r_a_hi;
  logic [W-1:0]  r_a_lo;
  logic [W-1:0]  r_b;
  logic [W:0]    r_p;
  logic [W-1:0]  r_q;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_quot;
  logic [W-1:0]  r_rem;
  logic          r_ovf;
  logic          r_busy;
  logic          r_done;

  logic          w_ovf_cond;
  logic [W:0]    w_t;
  logic          w_ge;
  logic [W:0]    w_p_next;
  logic [W-1:0]  w_q_next;

  // The quotient fits in W bits only when the upper dividend word is
  // strictly below the divisor; a zero divisor falls out of the same test
  // but is named explicitly for clarity.
  assign w_ovf_cond = (r_b == '0) || (r_a_hi >= r_b);

  // One restoring step: shift the next dividend bit into the partial
  // remainder, subtract the divisor when it fits.
  assign w_t      = {r_p[W-1:0], r_q[W-1]};
  assign w_ge     = (w_t >= {1'b0, r_b});
  assign w_p_next = w_ge ? (w_t - {1'b0, r_b}) : w_t;
  assign w_q_next = {r_q[W-2:0], w_ge};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.i_start) w_state_next = ST_CHECK;
      ST_CHECK: w_state_next = w_ovf_cond ? ST_DONE : ST_RUN;
      ST_RUN:   if (r_cnt == CNT_LAST) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_a_hi  <= '0;
      r_a_lo  <= '0;
      r_b     <= '0;
      r_p     <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // Status flags are decoded from the next state so they line up with
      // the state register and stay glitch-free registered outputs.
      r_busy  <= (w_state_next == ST_CHECK) || (w_state_next == ST_RUN);
      r_done  <= (w_state_next == ST_DONE);

      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            r_a_hi <= bus.i_a[2*W-1:W];
            r_a_lo <= bus.i_a[W-1:0];
            r_b    <= bus.i_b;
          end
        end
        ST_CHECK: begin
          if (w_ovf_cond) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_ovf  <= 1'b1;
          end else begin
            r_p   <= {1'b0, r_a_hi};
            r_q   <= r_a_lo;
            r_cnt <= '0;
          end
        end
        ST_RUN: begin
          r_p   <= w_p_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + 1'b1;
          // Published results only change on the way into DONE, so the
          // previous answer stays visible while the next one is computed.
          if (r_cnt == CNT_LAST) begin
            r_quot <= w_q_next;
            r_rem  <= w_p_next[W-1:0];
            r_ovf  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_quot     = r_quot;
  assign bus.o_rem      = r_rem;
  assign bus.o_overflow = r_ovf;
  assign bus.o_busy     = r_busy;
  assign bus.o_done     = r_done;

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - directed self-checking bench for the div block
module tb_div;
  localparam int W = 30;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  div_if #(.W(W)) bus ();

  div #(.W(W)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Partial remainder must never grow past W bits.
  always @(negedge clk) begin
    if (!rst && dut.r_p[W] !== 1'b0) begin
      n_miss++;
      $display("FAIL p_width: p[W]=%b required 0", dut.r_p[W]);
    end
  end

  // Issues one request and waits (bounded) for done. Returns at the negedge
  // where done is seen; edges counts the start-sampling edge as 1.
  task automatic run_op(input logic [2*W-1:0] a, input logic [W-1:0] b,
                        output int edges, output bit busy_ok);
    busy_ok = 1'b1;
    @(negedge clk);
    bus.i_a = a; bus.i_b = b; bus.i_start = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    bus.i_start = 1'b0;
    while (bus.o_done !== 1'b1 && edges < 100) begin
      if (bus.o_busy !== 1'b1) busy_ok = 1'b0;
      bus.i_a = {$urandom, $urandom};
      bus.i_b = W'($urandom);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (bus.o_busy !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (bus.o_busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b need 0", bus.o_busy); end
    n_vec++; if (bus.o_done !== 1'b0) begin n_miss++; $display("FAIL reset_done: got %b need 0", bus.o_done); end
    n_vec++; if (bus.o_quot !== '0) begin n_miss++; $display("FAIL reset_quot: got %0d need 0", bus.o_quot); end
    n_vec++; if (bus.o_rem !== '0) begin n_miss++; $display("FAIL reset_rem: got %0d need 0", bus.o_rem); end
    n_vec++; if (bus.o_overflow !== 1'b0) begin n_miss++; $display("FAIL reset_ovf: got %b need 0", bus.o_overflow); end
    rst = 1'b0;
  endtask

  task automatic test_normal(input string nm, input logic [2*W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] eq, input logic [W-1:0] er);
    int e; bit bok;
    run_op(a, b, e, bok);
    n_vec++; if (e !== 32) begin n_miss++; $display("FAIL %s_latency: got %0d edges need 32", nm, e); end
    n_vec++; if (bus.o_quot !== eq) begin n_miss++; $display("FAIL %s_quot: got %0d need %0d", nm, bus.o_quot, eq); end
    n_vec++; if (bus.o_rem !== er) begin n_miss++; $display("FAIL %s_rem: got %0d need %0d", nm, bus.o_rem, er); end
    n_vec++; if (bus.o_overflow !== 1'b0) begin n_miss++; $display("FAIL %s_ovf: got %b need 0", nm, bus.o_overflow); end
    n_vec++; if (!bok) begin n_miss++; $display("FAIL %s_busy: busy not contiguous (got 0 need 1)", nm); end
    @(negedge clk);
    n_vec++; if (bus.o_done !== 1'b0) begin n_miss++; $display("FAIL %s_done_pulse: got %b need 0", nm, bus.o_done); end
  endtask

  task automatic test_overflow(input string nm, input logic [2*W-1:0] a, input logic [W-1:0] b);
    int e; bit bok;
    run_op(a, b, e, bok);
    n_vec++; if (e !== 2) begin n_miss++; $display("FAIL %s_latency: got %0d edges need 2", nm, e); end
    n_vec++; if (bus.o_overflow !== 1'b1) begin n_miss++; $display("FAIL %s_ovf: got %b need 1", nm, bus.o_overflow); end
    n_vec++; if (bus.o_quot !== '0) begin n_miss++; $display("FAIL %s_quot: got %0d need 0", nm, bus.o_quot); end
    n_vec++; if (bus.o_rem !== '0) begin n_miss++; $display("FAIL %s_rem: got %0d need 0", nm, bus.o_rem); end
  endtask

  task automatic test_start_while_busy;
    int e; int dones; bit bok;
    bok = 1'b1;
    @(negedge clk);
    bus.i_a = 60'd1000; bus.i_b = 30'd9; bus.i_start = 1'b1;
    @(posedge clk); e = 1;
    @(negedge clk); bus.i_start = 1'b0;
    while (bus.o_done !== 1'b1 && e < 100) begin
      if (bus.o_busy !== 1'b1) bok = 1'b0;
      // RUN cycle 10: a second request with different operands
      bus.i_start = (e == 12);
      bus.i_a = 60'd50; bus.i_b = 30'd3;
      @(posedge clk); e++;
      @(negedge clk);
    end
    bus.i_start = 1'b0;
    n_vec++; if (e !== 32) begin n_miss++; $display("FAIL swb_latency: got %0d edges need 32", e); end
    n_vec++; if (bus.o_quot !== 30'd111) begin n_miss++; $display("FAIL swb_quot: got %0d need 111", bus.o_quot); end
    n_vec++; if (bus.o_rem !== 30'd1) begin n_miss++; $display("FAIL swb_rem: got %0d need 1", bus.o_rem); end
    n_vec++; if (!bok) begin n_miss++; $display("FAIL swb_busy: busy not contiguous (got 0 need 1)"); end
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_done === 1'b1 || bus.o_busy === 1'b1) dones++;
    end
    n_vec++; if (dones !== 0) begin n_miss++; $display("FAIL swb_single_done: got %0d extra active cycles need 0", dones); end
  endtask

  task automatic test_back_to_back;
    int e; int act; bit bok;
    run_op(60'd100, 30'd7, e, bok);
    // start raised on the done cycle must be dropped
    bus.i_a = 60'd200; bus.i_b = 30'd7; bus.i_start = 1'b1;
    @(negedge clk); bus.i_start = 1'b0;
    act = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_done === 1'b1 || bus.o_busy === 1'b1) act++;
    end
    n_vec++; if (act !== 0) begin n_miss++; $display("FAIL b2b_done_cycle_start: got %0d active cycles need 0", act); end
    // results hold once a new request has been accepted
    @(negedge clk);
    bus.i_a = 60'd200; bus.i_b = 30'd7; bus.i_start = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.i_start = 1'b0;
    n_vec++; if (bus.o_quot !== 30'd14) begin n_miss++; $display("FAIL b2b_hold_quot: got %0d need 14", bus.o_quot); end
    n_vec++; if (bus.o_rem !== 30'd2) begin n_miss++; $display("FAIL b2b_hold_rem: got %0d need 2", bus.o_rem); end
    e = 1;
    while (bus.o_done !== 1'b1 && e < 100) begin
      @(posedge clk); e++;
      @(negedge clk);
    end
    n_vec++; if (e !== 32) begin n_miss++; $display("FAIL b2b_latency: got %0d edges need 32", e); end
    n_vec++; if (bus.o_quot !== 30'd28 || bus.o_rem !== 30'd4) begin
      n_miss++; $display("FAIL b2b_result: got %0d r %0d need 28 r 4", bus.o_quot, bus.o_rem);
    end
  endtask

  task automatic test_reset_mid_op;
    int e; int dones;
    @(negedge clk);
    bus.i_a = 60'd77777; bus.i_b = 30'd123; bus.i_start = 1'b1;
    @(posedge clk); e = 1;
    @(negedge clk); bus.i_start = 1'b0;
    while (e < 17) begin
      @(posedge clk); e++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      n_miss++; $display("FAIL rmo_status: got busy=%b done=%b need 0 0", bus.o_busy, bus.o_done);
    end
    n_vec++; if (bus.o_quot !== '0 || bus.o_rem !== '0 || bus.o_overflow !== 1'b0) begin
      n_miss++; $display("FAIL rmo_outputs: got q=%0d r=%0d ovf=%b need 0 0 0", bus.o_quot, bus.o_rem, bus.o_overflow);
    end
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) dones++;
    end
    n_vec++; if (dones !== 0) begin n_miss++; $display("FAIL rmo_no_done: got %0d dones need 0", dones); end
    test_normal("rmo_after", 60'd77777, 30'd123, 30'd632, 30'd41);
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    rst = 1'b1;
    bus.i_start = 1'b0; bus.i_a = '0; bus.i_b = '0;
    test_reset();
    test_normal("basic", 60'd100, 30'd7, 30'd14, 30'd2);
    test_normal("mul_inverse", 60'd185595198769372101, 30'd234234234, 30'd792348734, 30'd12345);
    test_normal("boundary", {30'd4, 30'h3FFFFFFF}, 30'd5, 30'h3FFFFFFF, 30'd4);
    test_overflow("ovf_div0", 60'd12345, 30'd0);
    test_normal("after_ovf", 60'd100, 30'd7, 30'd14, 30'd2);
    test_overflow("ovf_equal", {30'd5, 30'd0}, 30'd5);
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
